onchip_ram_pipelined: RTL and testbench

ONCHIP_RAM_PIPELINED -- requirements
Module: onchip_ram_pipelined

---
 rtl/onchip_ram_pkg.sv | 14 +
 rtl/onchip_ram_rdpipe.sv | 48 ++++
 rtl/onchip_ram_pipelined.sv | 149 ++++++++++++++
 tb/tb_onchip_ram_pipelined.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_ram_pkg.sv
// Shared types and constants for the pipelined on-chip RAM.
package onchip_ram_pkg;

   // Controller state; ST_CLEAR exists only in builds with ONCHIP_RAM_CLEAR_EN.
   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Legal read latencies: array output register only, or one extra stage.
   localparam int RD_LAT_ARRAY = 1;
   localparam int RD_LAT_REG   = 2;

endpackage

// File: rtl/onchip_ram_rdpipe.sv
// Read-result delay line: LAT register stages of {valid, data}, all stages
// frozen while clken is low so an in-flight result is neither lost nor repeated.
module onchip_ram_rdpipe #(
   parameter int DATA_W = 32,
   parameter int LAT    = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clken,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   logic [LAT-1:0]             vld_q, vld_d;
   logic [LAT-1:0][DATA_W-1:0] dat_q, dat_d;
   logic [LAT:0]               vld_chain;
   logic [LAT:0][DATA_W-1:0]   dat_chain;

   assign vld_chain = {vld_q, in_valid};
   assign dat_chain = {dat_q, in_data};

   // Shift one stage per enabled cycle, otherwise hold every stage.
   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (clken) begin
         vld_d = vld_chain[LAT-1:0];
         dat_d = dat_chain[LAT-1:0];
      end
   end

   // Stage registers; reset empties the pipe and zeroes the output data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign out_valid = vld_q[LAT-1];
   assign out_data  = dat_q[LAT-1];

endmodule

// File: rtl/onchip_ram_pipelined.sv
// Pipelined single-port on-chip RAM with byte-lane writes and clock enable.
// Optional feature macro: ONCHIP_RAM_CLEAR_EN -- zero the whole array after
// every reset before accepting requests.
//
// state    | meaning
// ST_CLEAR | zeroing words 0..DEPTH-1, one per enabled cycle; requests refused
// ST_READY | accepting reads and writes
module onchip_ram_pipelined
   import onchip_ram_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 10024,
   parameter int ADDR_W       = 14,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                chipselect,
   input  logic                read,
   input  logic                write,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W/8-1:0] byteenable,
   input  logic [DATA_W-1:0]   writedata,
   input  logic                clken,
   output logic [DATA_W-1:0]   readdata,
   output logic                readdatavalid,
   output logic                waitrequest
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

   if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 128) begin : g_bad_data_w
      $error("onchip_ram_pipelined: DATA_W must be a multiple of 8 in 8..128");
   end
   if ((64'(1) << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
      $error("onchip_ram_pipelined: 2**ADDR_W must be >= DEPTH");
   end
   if (READ_LATENCY != RD_LAT_ARRAY && READ_LATENCY != RD_LAT_REG) begin : g_bad_lat
      $error("onchip_ram_pipelined: READ_LATENCY must be 1 or 2");
   end

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] be_mask;
   logic [DATA_W-1:0] wr_word, rd_word;
   logic [IDX_W-1:0]  addr_idx, wr_idx;
   logic              in_range, ready, accept, wr_acc, rd_acc, wr_en;

   for (genvar b = 0; b < NB; b++) begin : g_be_mask
      assign be_mask[b*8 +: 8] = {8{byteenable[b]}};
   end

   assign in_range = ({1'b0, address} < DEPTH_V);
   assign addr_idx = address[IDX_W-1:0];

`ifdef ONCHIP_RAM_CLEAR_EN
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

   // Clear sequencer: down-counter of words remaining, READY at terminal count.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (clken && state_q == ST_CLEAR) begin
         if (clr_cnt_q == '0) begin
            state_d = ST_READY;
         end else begin
            clr_cnt_d = clr_cnt_q - 1'b1;
         end
      end
   end

   // State and clear counter; reset always restarts the clear from word 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= LAST_IDX;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   assign ready = (state_q == ST_READY);
`else
   logic run_q, run_d;

   // Ready one edge after reset release; keeps waitrequest high during reset.
   always_comb begin
      run_d = 1'b1;
   end

   // Out-of-reset flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_q <= 1'b0;
      end else begin
         run_q <= run_d;
      end
   end

   assign ready = run_q;
`endif

   assign waitrequest = ~clken | ~ready;
   assign accept      = chipselect & (read | write) & ~waitrequest;
   assign wr_acc      = accept & write;
   assign rd_acc      = accept & read & ~write;

   // Write port: byte-lane merge for host writes, zero fill while clearing.
   always_comb begin
      wr_en   = wr_acc & in_range;
      wr_idx  = addr_idx;
      wr_word = (mem_q[addr_idx] & ~be_mask) | (writedata & be_mask);
`ifdef ONCHIP_RAM_CLEAR_EN
      if (clken && state_q == ST_CLEAR) begin
         wr_en   = 1'b1;
         wr_idx  = LAST_IDX - clr_cnt_q;
         wr_word = '0;
      end
`endif
   end

   // Storage array; deliberately not reset so contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_word;
      end
   end

   assign rd_word = in_range ? mem_q[addr_idx] : '0;

   onchip_ram_rdpipe #(
      .DATA_W (DATA_W),
      .LAT    (READ_LATENCY)
   ) u_rdpipe (
      .clk       (clk),
      .reset_n   (reset_n),
      .clken     (clken),
      .in_valid  (rd_acc),
      .in_data   (rd_word),
      .out_valid (readdatavalid),
      .out_data  (readdata)
   );

endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// Self-checking bench: two instances (READ_LATENCY 1 and 2) share stimulus and
// are compared against a word-array model with a read-result scoreboard.
module tb_onchip_ram_pipelined;

`ifdef ONCHIP_RAM_CLEAR_EN
   localparam bit CLR   = 1'b1;
   localparam int DEPTH = 16;
`else
   localparam bit CLR   = 1'b0;
   localparam int DEPTH = 40;
`endif
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          chipselect = 1'b0, read = 1'b0, write = 1'b0, clken = 1'b1;
   logic [AW-1:0] address = '0;
   logic [3:0]    byteenable = '0;
   logic [31:0]   writedata = '0;
   logic [31:0]   rdata0, rdata1;
   logic          rvalid0, rvalid1, wreq0, wreq1;

   onchip_ram_pipelined #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .read(read), .write(write),
      .address(address), .byteenable(byteenable), .writedata(writedata), .clken(clken),
      .readdata(rdata0), .readdatavalid(rvalid0), .waitrequest(wreq0));

   onchip_ram_pipelined #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .read(read), .write(write),
      .address(address), .byteenable(byteenable), .writedata(writedata), .clken(clken),
      .readdata(rdata1), .readdatavalid(rvalid1), .waitrequest(wreq1));

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] m_mem [DEPTH];
   bit          m_ready = 1'b0;
   int          m_clr_left = DEPTH;
   int          e = 0;
   logic [31:0] q_data [$];
   int          q_edge [$];
   int          hd [2];
   bit          popped [2];
   logic [31:0] pop_data [2];
   int          pop_cnt [2];

   typedef struct {
      bit          w;
      bit          r;
      int          a;
      logic [3:0]  be;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit cs, input bit r, input bit w, input int a,
                        input logic [3:0] be, input logic [31:0] d, input bit ce);
      chipselect = cs;
      read       = r;
      write      = w;
      address    = AW'(a);
      byteenable = be;
      writedata  = d;
      clken      = ce;
   endtask

   task automatic idle(input int n);
      drive(0, 0, 0, 0, 4'h0, 32'h0, 1);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // One clock: check outputs against the model, take the edge, advance the model.
   task automatic cycle();
      bit          due, v_k, w_k, exp_wait, acc;
      logic [31:0] d_k;
      #3;
      if (!reset_n) begin
         q_data.delete();
         q_edge.delete();
         hd[0] = 0;
         hd[1] = 0;
         m_ready = 1'b0;
         m_clr_left = DEPTH;
      end
      exp_wait = !reset_n || !clken || !m_ready;
      for (int k = 0; k < 2; k++) begin
         v_k = (k == 0) ? rvalid0 : rvalid1;
         w_k = (k == 0) ? wreq0 : wreq1;
         d_k = (k == 0) ? rdata0 : rdata1;
         chk($sformatf("waitrequest_lat%0d", k + 1), w_k, exp_wait);
         due = reset_n && (hd[k] < q_data.size()) && (q_edge[hd[k]] + k + 1 == e);
         chk($sformatf("readdatavalid_lat%0d", k + 1), v_k, due);
         if (due && v_k) chk($sformatf("readdata_lat%0d", k + 1), d_k, q_data[hd[k]]);
         if (!reset_n) chk($sformatf("reset_readdata_lat%0d", k + 1), d_k, 0);
         if (due && clken) begin
            popped[k]   = 1'b1;
            pop_data[k] = d_k;
            pop_cnt[k]++;
            hd[k]++;
         end
      end
      acc = reset_n && chipselect && (read || write) && clken && m_ready;
      @(posedge clk);
      #1;
      if (reset_n) begin
         if (acc && write && int'(address) < DEPTH) begin
            for (int b = 0; b < 4; b++)
               if (byteenable[b]) m_mem[int'(address)][b*8 +: 8] = writedata[b*8 +: 8];
         end
         if (acc && read && !write) begin
            q_data.push_back((int'(address) < DEPTH) ? m_mem[int'(address)] : 32'h0);
            q_edge.push_back(e);
         end
         if (CLR) begin
            if (m_clr_left > 0 && clken) begin
               m_mem[DEPTH - m_clr_left] = 32'h0;
               m_clr_left--;
            end
            m_ready = (m_clr_left == 0);
         end else begin
            m_ready = 1'b1;
         end
         if (clken) e++;
      end
   endtask

   // Counts enabled cycles with waitrequest high right after reset release.
   task automatic startup_count(input string name);
      int wcnt = 0;
      bit done = 1'b0;
      drive(0, 0, 0, 0, 4'h0, 32'h0, 1);
      for (int i = 0; i < DEPTH + 8; i++) begin
         if (!done) begin
            if (wreq0) wcnt++;
            else done = 1'b1;
         end
         cycle();
      end
      chk(name, wcnt, CLR ? DEPTH : 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl [15];
      tbl[0]  = '{1, 0, 5,         4'hF, 32'hDEADBEEF, 32'h0};
      tbl[1]  = '{0, 1, 5,         4'h0, 32'h0,        32'hDEADBEEF};
      tbl[2]  = '{1, 0, 5,         4'h3, 32'h00001234, 32'h0};
      tbl[3]  = '{0, 1, 5,         4'h0, 32'h0,        32'hDEAD1234};
      tbl[4]  = '{1, 0, DEPTH - 1, 4'hF, 32'hA5A5A5A5, 32'h0};
      tbl[5]  = '{1, 0, DEPTH,     4'hF, 32'hFFFFFFFF, 32'h0};
      tbl[6]  = '{0, 1, DEPTH,     4'h0, 32'h0,        32'h0};
      tbl[7]  = '{0, 1, DEPTH - 1, 4'h0, 32'h0,        32'hA5A5A5A5};
      tbl[8]  = '{1, 0, 0,         4'hF, 32'h11223344, 32'h0};
      tbl[9]  = '{1, 0, 0,         4'h4, 32'hAABBCCDD, 32'h0};
      tbl[10] = '{0, 1, 0,         4'h0, 32'h0,        32'h11BB3344};
      tbl[11] = '{1, 1, 7,         4'hF, 32'h77777777, 32'h0};
      tbl[12] = '{0, 1, 7,         4'h0, 32'h0,        32'h77777777};
      tbl[13] = '{1, 0, 63,        4'hF, 32'h12345678, 32'h0};
      tbl[14] = '{0, 1, 63,        4'h0, 32'h0,        32'h0};

      hd[0] = 0; hd[1] = 0;
      pop_cnt[0] = 0; pop_cnt[1] = 0;

      reset_n = 1'b0;
      idle(3);
      reset_n = 1'b1;
      startup_count("startup_wait_cycles");

      if (!CLR) begin
         for (int a = 0; a < DEPTH; a++) begin
            drive(1, 0, 1, a, 4'hF, $urandom, 1);
            cycle();
         end
      end
      for (int a = 0; a < DEPTH; a++) begin
         drive(1, 1, 0, a, 4'h0, 32'h0, 1);
         cycle();
      end
      idle(3);

      for (int i = 0; i < 15; i++) begin
         popped[0] = 1'b0;
         popped[1] = 1'b0;
         drive(1, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].be, tbl[i].d, 1);
         cycle();
         idle(3);
         for (int k = 0; k < 2; k++) begin
            if (tbl[i].r && !tbl[i].w) begin
               chk($sformatf("tbl%0d_beat_lat%0d", i, k + 1), popped[k], 1);
               chk($sformatf("tbl%0d_data_lat%0d", i, k + 1), pop_data[k], tbl[i].exp);
            end else if (tbl[i].r) begin
               chk($sformatf("tbl%0d_rdwr_nobeat_lat%0d", i, k + 1), popped[k], 0);
            end
         end
      end

      // Read in the cycle right after a write to the same word.
      popped[0] = 1'b0;
      popped[1] = 1'b0;
      drive(1, 0, 1, 9, 4'hF, 32'h0BADF00D, 1);
      cycle();
      drive(1, 1, 0, 9, 4'h0, 32'h0, 1);
      cycle();
      idle(3);
      for (int k = 0; k < 2; k++)
         chk($sformatf("raw_data_lat%0d", k + 1), pop_data[k], 32'h0BADF00D);

      // Back-to-back burst of 8 reads with a 3-cycle clken stall in the middle.
      pop_cnt[0] = 0;
      pop_cnt[1] = 0;
      for (int a = 0; a < 8; a++) begin
         if (a == 4) begin
            for (int s = 0; s < 3; s++) begin
               drive(1, 1, 0, a, 4'h0, 32'h0, 0);
               cycle();
            end
         end
         drive(1, 1, 0, a, 4'h0, 32'h0, 1);
         cycle();
      end
      idle(4);
      for (int k = 0; k < 2; k++)
         chk($sformatf("burst_beats_lat%0d", k + 1), pop_cnt[k], 8);

      for (int i = 0; i < 600; i++) begin
         drive(($urandom % 4) != 0, $urandom % 2, ($urandom % 3) == 0,
               $urandom_range(0, 63), 4'($urandom), $urandom, ($urandom % 8) != 0);
         cycle();
      end
      idle(4);

      // Reset one cycle after an accepted read aborts it.
      drive(1, 1, 0, 5, 4'h0, 32'h0, 1);
      cycle();
      drive(0, 0, 0, 0, 4'h0, 32'h0, 1);
      reset_n = 1'b0;
      cycle();
      chk("abort_valid_lat1", rvalid0, 0);
      chk("abort_valid_lat2", rvalid1, 0);
      cycle();
      chk("abort_valid2_lat2", rvalid1, 0);
      reset_n = 1'b1;
      startup_count("restart_wait_cycles");
      for (int a = 0; a < 8; a++) begin
         drive(1, 1, 0, a, 4'h0, 32'h0, 1);
         cycle();
      end
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
